// File: rtl/copyread_pkg.sv
// Shared definitions for the copy-read lane arbiter: default widths, lane-slice
// field offsets and a one-hot decode helper used by every lane selector.
package copyread_pkg;

   localparam int DEF_NUM_REQ  = 16;
   localparam int DEF_LOG_REQ  = 4;
   localparam int DEF_ADDR_W   = 9;
   localparam int DEF_DATA_W   = 64;
   localparam int DEF_FIFO_DEP = 4;
   localparam int MAX_REQ      = 64;

   // Each lane slice is packed as {addr, bv, data} with data in the low bits.
   function automatic int data_lsb();
      return 0;
   endfunction

   function automatic int data_msb(input int data_w);
      return data_w - 1;
   endfunction

   function automatic int bv_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int bv_msb(input int data_w);
      return data_w + data_w / 8 - 1;
   endfunction

   function automatic int addr_lsb(input int data_w);
      return data_w + data_w / 8;
   endfunction

   function automatic int addr_msb(input int addr_w, input int data_w);
      return data_w + data_w / 8 + addr_w - 1;
   endfunction

   function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational lane selector: round-robin from a one-hot base pointer, or fixed
// priority with lane 0 highest. Produces a one-hot grant and its index.
module rr_arbiter_core
   import copyread_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = DEF_LOG_REQ,
   parameter int RR_EN   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] base,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] pick;

   // Requests at or above base win first; if none, the wrap-around falls back to
   // the full request vector, whose lowest set bit is then the next in rotation.
   always_comb begin
      masked = req & ~(base - NUM_REQ'(1));
      pick   = req;
      if (RR_EN != 0 && masked != '0) pick = masked;
      grant  = '0;
      if (en) grant = pick & (~pick + NUM_REQ'(1));
      idx    = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
   end

endmodule

// File: rtl/copyread_rr_arbiter.sv
// Arbitrates copy-read requests from the parser lanes onto the shared BRAM read
// path: one grant per cycle, a payload register stage, then a small output FIFO.
module copyread_rr_arbiter
   import copyread_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int LOG_REQ  = DEF_LOG_REQ,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int FIFO_DEP = DEF_FIFO_DEP,
   parameter int RR_EN    = 1
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [NUM_REQ*(ADDR_W+DATA_W/8+DATA_W)-1:0]    req_data,
   input  logic [NUM_REQ-1:0]                             req_valid,
   output logic [NUM_REQ-1:0]                             req_grant,
   output logic [ADDR_W-1:0]                              out_addr,
   output logic [DATA_W/8-1:0]                            out_bv,
   output logic [DATA_W-1:0]                              out_data,
   output logic [LOG_REQ-1:0]                             out_id,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [$clog2(FIFO_DEP):0]                      fifo_cnt
);

   localparam int LANE_W = ADDR_W + DATA_W / 8 + DATA_W;
   localparam int PTR_W  = $clog2(FIFO_DEP);
   localparam int CNT_W  = PTR_W + 1;
   localparam int D_LSB  = data_lsb();
   localparam int D_MSB  = data_msb(DATA_W);
   localparam int B_LSB  = bv_lsb(DATA_W);
   localparam int B_MSB  = bv_msb(DATA_W);
   localparam int A_LSB  = addr_lsb(DATA_W);
   localparam int A_MSB  = addr_msb(ADDR_W, DATA_W);

   logic [NUM_REQ-1:0] base;
   logic               can_acc;
   logic               arb_en;
   logic [LOG_REQ-1:0] grant_idx;
   logic               s1_valid;
   logic [LANE_W-1:0]  s1_word;
   logic [LOG_REQ-1:0] s1_id;
   logic [LANE_W-1:0]  fifo_word [FIFO_DEP];
   logic [LOG_REQ-1:0] fifo_id   [FIFO_DEP];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt;
   logic               pop;
   logic [LANE_W-1:0]  head_word;

   // The beat sitting in stage 1 has already claimed a FIFO slot, so grants are
   // throttled on occupancy plus in-flight; out_ready never reaches the grant.
   assign can_acc = (32'(cnt) + 32'(s1_valid)) < FIFO_DEP;
   assign arb_en  = can_acc && !rst;

   rr_arbiter_core #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (LOG_REQ),
      .RR_EN   (RR_EN)
   ) u_core (
      .req   (req_valid),
      .base  (base),
      .en    (arb_en),
      .grant (req_grant),
      .idx   (grant_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         base     <= NUM_REQ'(1);
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= |req_grant;
         if (|req_grant) base <= {req_grant[NUM_REQ-2:0], req_grant[NUM_REQ-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (|req_grant) begin
         s1_word <= req_data[int'(grant_idx)*LANE_W +: LANE_W];
         s1_id   <= grant_idx;
      end
   end

   assign pop = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (s1_valid) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CNT_W'(s1_valid) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (s1_valid && !rst) begin
         fifo_word[wr_ptr] <= s1_word;
         fifo_id[wr_ptr]   <= s1_id;
      end
   end

   assign head_word = fifo_word[rd_ptr];
   assign out_addr  = head_word[A_MSB:A_LSB];
   assign out_bv    = head_word[B_MSB:B_LSB];
   assign out_data  = head_word[D_MSB:D_LSB];
   assign out_id    = fifo_id[rd_ptr];
   assign out_valid = (cnt != '0);
   assign fifo_cnt  = cnt;

endmodule
